// File: rtl/scaler_pkg.sv
// -----------------------------------------------------------------------------
// scaler_pkg
// Shared constants and types for the scaler_v configuration sequencer.
//   FRAC_W      : fractional bits of the vertical scale step (unsigned 4.12)
//   STEP_ONE    : step value meaning a scale of exactly 1.000
//   cfg_state_t : sequencer states (IDLE -> DIV -> PEND -> IDLE)
// -----------------------------------------------------------------------------
package scaler_pkg;

  localparam int FRAC_W = 12;
  localparam int STEP_W = 16;
  localparam logic [STEP_W-1:0] STEP_ONE = 16'd4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PEND = 2'd2
  } cfg_state_t;

endpackage : scaler_pkg

// File: rtl/scaler_v_cfg_ctrl_seq_udiv.sv
// -----------------------------------------------------------------------------
// seq_udiv
// Sequential restoring unsigned divider, one quotient bit per clock.
// A start pulse loads the operands; exactly DVD_W cycles later done pulses
// for one cycle and quotient/sat hold the result until the next start.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load dividend/divisor and begin a division
//   dividend   : DVD_W-bit numerator
//   divisor    : DVS_W-bit denominator (caller guarantees non-zero)
//   done       : 1-cycle pulse when quotient is valid
//   quotient   : OUT_W-bit quotient, clamped to all-ones on overflow
//   sat        : quotient did not fit in OUT_W bits
// -----------------------------------------------------------------------------
module seq_udiv #(
  parameter int DVD_W = 23,
  parameter int DVS_W = 11,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [OUT_W-1:0] quotient,
  output logic             sat
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_r;
  logic [DVS_W-1:0] dvs_r;
  logic [DVD_W-1:0] dq_r;     // dividend shifts out the top, quotient bits shift in
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;

  logic [DVS_W:0]   rem_sh_s;
  logic             ge_s;
  logic [DVS_W-1:0] rem_nxt_s;

  // Trial subtraction for one restoring step
  always_comb begin
    rem_sh_s  = {rem_r, dq_r[DVD_W-1]};
    ge_s      = (rem_sh_s >= {1'b0, dvs_r});
    rem_nxt_s = rem_sh_s[DVS_W-1:0];
    if (ge_s) begin
      // Remainder before the step is < divisor, so the difference fits DVS_W bits
      rem_nxt_s = DVS_W'(rem_sh_s - {1'b0, dvs_r});
    end else begin
      rem_nxt_s = rem_sh_s[DVS_W-1:0];
    end
  end

  // Division state: operand load on start, then one quotient bit per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r  <= DVS_W'(0);
      dvs_r  <= DVS_W'(0);
      dq_r   <= DVD_W'(0);
      cnt_r  <= CNT_W'(0);
      done_r <= 1'b0;
    end else if (start) begin
      rem_r  <= DVS_W'(0);
      dvs_r  <= divisor;
      dq_r   <= dividend;
      cnt_r  <= CNT_W'(DVD_W);
      done_r <= 1'b0;
    end else if (cnt_r != CNT_W'(0)) begin
      rem_r  <= rem_nxt_s;
      dq_r   <= {dq_r[DVD_W-2:0], ge_s};
      cnt_r  <= cnt_r - CNT_W'(1);
      done_r <= (cnt_r == CNT_W'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done     = done_r;
  assign sat      = |dq_r[DVD_W-1:OUT_W];
  assign quotient = sat ? {OUT_W{1'b1}} : dq_r[OUT_W-1:0];

endmodule : seq_udiv

// File: rtl/scaler_v_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// scaler_v_cfg_ctrl
// Frame-synchronous configuration sequencer for scaler_v. A request
// (in_lines, out_lines, line_size) is turned into the 4.12 vertical scale
// step by a sequential divider and applied only on a vs_in boundary, so a
// frame is never scaled with mixed settings. in_lines==0 selects the input
// line count measured over the last complete frame.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   cfg_valid / cfg_ready    : request handshake (ready in IDLE and PEND)
//   cfg_in_lines             : input lines per frame, 0 = measured count
//   cfg_out_lines            : output lines per frame
//   cfg_line_size            : forwarded to vertical_scale_line_size
//   hs_in, vs_in             : video line / frame strobes
//   vertical_scale_step      : 4.12 step to scaler_v
//   vertical_scale_line_size : line size to scaler_v
//   measured_lines           : hs_in count of last complete frame
//   cfg_applied              : 1-cycle pulse when new values take effect
//   cfg_err                  : 1-cycle pulse when a request is rejected
//   busy                     : sequencer not idle
// -----------------------------------------------------------------------------
module scaler_v_cfg_ctrl #(
  parameter int LINES_W           = 11,
  parameter int STEP_W            = 16,
  parameter int FRAC_W            = 12,
  parameter int LINE_SIZE_DEFAULT = 1100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LINES_W-1:0] cfg_in_lines,
  input  logic [LINES_W-1:0] cfg_out_lines,
  input  logic [15:0]        cfg_line_size,
  input  logic               hs_in,
  input  logic               vs_in,
  output logic [STEP_W-1:0]  vertical_scale_step,
  output logic [15:0]        vertical_scale_line_size,
  output logic [LINES_W-1:0] measured_lines,
  output logic               cfg_applied,
  output logic               cfg_err,
  output logic               busy
);

  import scaler_pkg::*;

  localparam int DVD_W = LINES_W + FRAC_W;
  localparam logic [STEP_W-1:0] STEP_RST = STEP_W'(1) << FRAC_W;
  localparam logic [15:0]       SIZE_RST = 16'(LINE_SIZE_DEFAULT);

  // Line counter increment that sticks at the maximum count
  function automatic logic [LINES_W-1:0] sat_inc(input logic [LINES_W-1:0] v,
                                                 input logic               inc);
    logic [LINES_W-1:0] r;
    if (inc && (v != {LINES_W{1'b1}})) begin
      r = v + LINES_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  cfg_state_t         state_r, state_nxt_s;
  logic [LINES_W-1:0] cntr_r;
  logic [LINES_W-1:0] measured_r;
  logic [STEP_W-1:0]  step_r, shadow_step_r;
  logic [15:0]        size_r, shadow_size_r, req_size_r;
  logic               applied_r, err_r, ready_r, busy_r;

  logic               accept_s, req_ok_s;
  logic [LINES_W-1:0] divisor_s;
  logic [DVD_W-1:0]   dividend_s;
  logic               div_start_s, shadow_load_s, apply_s, err_s;
  logic               div_done_s, div_sat_s;
  logic [STEP_W-1:0]  div_q_s;

  // Request decode: pick the divisor and check the request is usable
  always_comb begin
    accept_s   = cfg_valid && ready_r;
    dividend_s = {cfg_out_lines, FRAC_W'(0)};
    if (cfg_in_lines != LINES_W'(0)) begin
      divisor_s = cfg_in_lines;
    end else begin
      divisor_s = measured_r;
    end
    req_ok_s = (divisor_s != LINES_W'(0)) && (cfg_out_lines != LINES_W'(0));
  end

  seq_udiv #(
    .DVD_W (DVD_W),
    .DVS_W (LINES_W),
    .OUT_W (STEP_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .dividend (dividend_s),
    .divisor  (divisor_s),
    .done     (div_done_s),
    .quotient (div_q_s),
    .sat      (div_sat_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && req_ok_s) begin
          state_nxt_s = DIV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIV: begin
        if (div_done_s) begin
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = DIV;
        end
      end
      PEND: begin
        // A new request replaces the pending one; vs_in alone applies it
        if (accept_s) begin
          state_nxt_s = req_ok_s ? DIV : IDLE;
        end else if (vs_in) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output strobes
  always_comb begin
    div_start_s   = 1'b0;
    shadow_load_s = 1'b0;
    apply_s       = 1'b0;
    err_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          div_start_s = req_ok_s;
          err_s       = !req_ok_s;
        end else begin
          div_start_s = 1'b0;
        end
      end
      DIV: begin
        shadow_load_s = div_done_s;
      end
      PEND: begin
        // vs_in applies the pending values even when a new request arrives
        apply_s = vs_in;
        if (accept_s) begin
          div_start_s = req_ok_s;
          err_s       = !req_ok_s;
        end else begin
          div_start_s = 1'b0;
        end
      end
      default: begin
        div_start_s = 1'b0;
      end
    endcase
  end

  // Handshake and status flags, registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == PEND);
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Line counter and last-frame measurement; hs_in with vs_in ends the frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cntr_r     <= LINES_W'(0);
      measured_r <= LINES_W'(0);
    end else if (vs_in) begin
      measured_r <= sat_inc(cntr_r, hs_in);
      cntr_r     <= LINES_W'(0);
    end else begin
      cntr_r     <= sat_inc(cntr_r, hs_in);
    end
  end

  // Request capture and shadow registers holding the next frame's settings
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_size_r    <= SIZE_RST;
      shadow_step_r <= STEP_RST;
      shadow_size_r <= SIZE_RST;
    end else begin
      if (div_start_s) begin
        req_size_r <= cfg_line_size;
      end
      if (shadow_load_s) begin
        shadow_step_r <= div_sat_s ? {STEP_W{1'b1}} : div_q_s;
        shadow_size_r <= req_size_r;
      end
    end
  end

  // Live outputs to scaler_v, updated only on the apply edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_r    <= STEP_RST;
      size_r    <= SIZE_RST;
      applied_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      if (apply_s) begin
        step_r <= shadow_step_r;
        size_r <= shadow_size_r;
      end
      applied_r <= apply_s;
      err_r     <= err_s;
    end
  end

  assign cfg_ready                = ready_r;
  assign busy                     = busy_r;
  assign vertical_scale_step      = step_r;
  assign vertical_scale_line_size = size_r;
  assign measured_lines           = measured_r;
  assign cfg_applied              = applied_r;
  assign cfg_err                  = err_r;

endmodule : scaler_v_cfg_ctrl
